// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the branch resolve unit and its in-flight queue.
package branch_resolve_unit_pkg;

    localparam int BRU_PC_WIDTH = 32;
    localparam logic [BRU_PC_WIDTH-1:0] PC_INCR = 32'd4;

    typedef struct packed {
        logic [BRU_PC_WIDTH-1:0] pc;
        logic                    pred;
    } branch_entry_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch/execute-facing bus of the branch resolve unit: alloc, resolve and predictor update.
interface branch_resolve_unit_if
    import branch_resolve_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int PC_WIDTH   = BRU_PC_WIDTH
);
    logic                  alloc_valid;
    logic                  alloc_ready;
    logic [PC_WIDTH-1:0]   alloc_pc;
    logic                  alloc_pred;
    logic                  resolve_valid;
    logic                  resolve_taken;
    logic [PC_WIDTH-1:0]   resolve_target;
    logic                  update;
    logic [ADDR_WIDTH-1:0] updateAddr;
    logic                  branchTaken;
    logic                  flush;
    logic [PC_WIDTH-1:0]   redirect_pc;

    modport master (
        output alloc_valid, alloc_pc, alloc_pred,
        output resolve_valid, resolve_taken, resolve_target,
        input  alloc_ready, update, updateAddr, branchTaken, flush, redirect_pc
    );

    modport slave (
        input  alloc_valid, alloc_pc, alloc_pred,
        input  resolve_valid, resolve_taken, resolve_target,
        output alloc_ready, update, updateAddr, branchTaken, flush, redirect_pc
    );

endinterface

// File: rtl/branch_resolve_unit_fifo.sv
// In-order circular buffer of in-flight branches; clear wins over push/pop.
module branch_inflight_fifo
    import branch_resolve_unit_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = branch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  entry_t                 din,
    output entry_t                 head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W:0]   count;
    entry_t           mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full && !clear;
    assign do_pop    = pop && !empty && !clear;
    assign head      = mem[head_ptr];
    assign occupancy = count;

    always_ff @(posedge clk) begin
        if (do_push) mem[tail_ptr] <= din;
    end

    // DEPTH is a power of two, so pointer wrap is plain binary overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (clear) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (do_push) tail_ptr <= tail_ptr + 1'b1;
            if (do_pop)  head_ptr <= head_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves in-flight predicted branches in order, updates the predictor and redirects fetch on mispredict.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int PC_WIDTH   = BRU_PC_WIDTH,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    branch_resolve_unit_if.slave   bus,
    output logic                   resolve_err,
    output logic [CNT_WIDTH-1:0]   mispredict_count,
    output logic [$clog2(DEPTH):0] occupancy
);
    branch_entry_t head;
    branch_entry_t alloc_entry;
    logic          full;
    logic          empty;
    logic          do_resolve;
    logic          mispredict;

    assign alloc_entry     = '{pc: bus.alloc_pc, pred: bus.alloc_pred};
    assign bus.alloc_ready = !full;
    assign do_resolve      = bus.resolve_valid && !empty;
    assign mispredict      = do_resolve && (bus.resolve_taken != head.pred);

    // A mispredict squashes every younger entry, including a same-cycle alloc.
    branch_inflight_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (branch_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (bus.alloc_valid && !full),
        .pop       (do_resolve && !mispredict),
        .clear     (mispredict),
        .din       (alloc_entry),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .occupancy (occupancy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.update       <= 1'b0;
            bus.updateAddr   <= '0;
            bus.branchTaken  <= 1'b0;
            bus.flush        <= 1'b0;
            bus.redirect_pc  <= '0;
            resolve_err      <= 1'b0;
            mispredict_count <= '0;
        end else begin
            bus.update <= do_resolve;
            bus.flush  <= mispredict;
            if (do_resolve) begin
                bus.updateAddr  <= head.pc[ADDR_WIDTH+1:2];
                bus.branchTaken <= bus.resolve_taken;
            end
            if (mispredict) begin
                bus.redirect_pc <= bus.resolve_taken ? bus.resolve_target : head.pc + PC_INCR;
                if (mispredict_count != '1) mispredict_count <= mispredict_count + 1'b1;
            end
            if (bus.resolve_valid && empty) resolve_err <= 1'b1;
        end
    end

endmodule
